// File: rtl/risc_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// risc_seq_ctrl_if
// Bundle between the sequencer and the accumulator-core datapath.
//   opcode      : instruction-register opcode (OPCODE_W bits)
//   zero        : accumulator == 0 flag
//   mem_ready   : memory handshake, high when the access completes
//   resume      : single-cycle pulse that leaves the halted state
//   mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr : datapath strobes
//   halt        : halt indication
//   phase       : encoded sequencer state for debug
//   timeout_err : sticky memory-timeout flag
// Modports: master = sequencer side, slave = datapath/memory side.
// ---------------------------------------------------------------------------
interface risc_seq_ctrl_if #(
    parameter int OPCODE_W = 3
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                resume;
    logic                mem_rd;
    logic                load_ir;
    logic                inc_pc;
    logic                load_ac;
    logic                load_pc;
    logic                mem_wr;
    logic                halt;
    logic [3:0]          phase;
    logic                timeout_err;

    modport master (
        input  opcode, zero, mem_ready, resume,
        output mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr,
        output halt, phase, timeout_err
    );

    modport slave (
        output opcode, zero, mem_ready, resume,
        input  mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr,
        input  halt, phase, timeout_err
    );
endinterface

// File: rtl/risc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// risc_seq_ctrl
// Eight-phase fetch/execute sequencer for the accumulator RISC core, with a
// memory-ready wait handshake, wait-state timeout, a halted state with
// resume, and a debug phase output.
// Ports:
//   clk     : rising-edge clock
//   rst_    : asynchronous active-low reset
//   step_en : (CTRL_SINGLE_STEP_EN only) park in HALTED after each STORE
//   bus     : risc_seq_ctrl_if.master (opcode/zero/mem_ready/resume in,
//             strobes/halt/phase/timeout_err out)
// Parameters:
//   OPCODE_W : opcode width (>=3); any nonzero bit above bit 2 means HLT
//   WAIT_MAX : consecutive mem_ready-low cycles tolerated, 1..255
// Optional feature macro: CTRL_SINGLE_STEP_EN
// ---------------------------------------------------------------------------
module risc_seq_ctrl #(
    parameter int OPCODE_W = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst_,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            step_en,
`endif
    risc_seq_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3,
        OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7
    } op_e;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    // Wider opcodes: anything outside the 3-bit space is treated as HLT.
    function automatic op_e decode_op(input logic [OPCODE_W-1:0] raw);
        logic [OPCODE_W-1:0] upper;
        upper = raw >> 3;
        if (upper != '0) return OP_HLT;
        return op_e'(raw[2:0]);
    endfunction

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_err_q, timeout_err_d;

    op_e  op;
    logic is_aluop;
    logic wait_phase;

    assign op         = decode_op(bus.opcode);
    assign is_aluop   = (op == OP_ADD) || (op == OP_AND) ||
                        (op == OP_XOR) || (op == OP_LDA);
    // Only memory-reading phases stall on mem_ready.
    assign wait_phase = (state_q == S_INST_FETCH) ||
                        ((state_q == S_OP_FETCH) && is_aluop);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q       <= S_INST_ADDR;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next state. The counter defaults to 0 so it clears on every state
    // change; it only counts while a wait phase is being held.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        timeout_err_d = timeout_err_q;
        if (wait_phase && !bus.mem_ready) begin
            if (wait_cnt_q == WAIT_LIMIT) begin
                state_d       = S_HALTED;
                timeout_err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                S_INST_ADDR:  state_d = S_INST_FETCH;
                S_INST_FETCH: state_d = S_INST_LOAD;
                S_INST_LOAD:  state_d = S_IDLE;
                S_IDLE:       state_d = S_OP_ADDR;
                S_OP_ADDR:    state_d = (op == OP_HLT) ? S_HALTED : S_OP_FETCH;
                S_OP_FETCH:   state_d = S_ALU_OP;
                S_ALU_OP:     state_d = S_STORE;
`ifdef CTRL_SINGLE_STEP_EN
                S_STORE:      state_d = step_en ? S_HALTED : S_INST_ADDR;
`else
                S_STORE:      state_d = S_INST_ADDR;
`endif
                S_HALTED: begin
                    // A timeout is fatal until reset: resume cannot clear it.
                    if (bus.resume && !timeout_err_q) state_d = S_INST_ADDR;
                end
                default:      state_d = S_INST_ADDR;
            endcase
        end
    end

    // Moore strobes: depend on state and opcode/zero only, never mem_ready.
    always_comb begin
        bus.mem_rd  = 1'b0;
        bus.load_ir = 1'b0;
        bus.inc_pc  = 1'b0;
        bus.load_ac = 1'b0;
        bus.load_pc = 1'b0;
        bus.mem_wr  = 1'b0;
        bus.halt    = 1'b0;
        case (state_q)
            S_INST_FETCH: bus.mem_rd = 1'b1;
            S_INST_LOAD, S_IDLE: begin
                bus.mem_rd  = 1'b1;
                bus.load_ir = 1'b1;
            end
            S_OP_ADDR: begin
                bus.inc_pc = 1'b1;
                bus.halt   = (op == OP_HLT);
            end
            S_OP_FETCH: bus.mem_rd = is_aluop;
            S_ALU_OP: begin
                bus.mem_rd  = is_aluop;
                bus.load_ac = is_aluop;
                bus.inc_pc  = (op == OP_SKZ) && bus.zero;
                bus.load_pc = (op == OP_JMP);
            end
            S_STORE: begin
                bus.mem_rd  = is_aluop;
                bus.load_ac = is_aluop;
                bus.load_pc = (op == OP_JMP);
                bus.inc_pc  = (op == OP_JMP);
                bus.mem_wr  = (op == OP_STO);
            end
            S_HALTED: bus.halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.phase       = state_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_risc_seq_ctrl.sv
module tb_risc_seq_ctrl;
    localparam int OPW  = 4;
    localparam int WMAX = 5;

    logic clk = 1'b0;
    logic rst_;
    logic step_en;
    always #5 clk = ~clk;

    risc_seq_ctrl_if #(.OPCODE_W(OPW)) bus ();

    risc_seq_ctrl #(.OPCODE_W(OPW), .WAIT_MAX(WMAX)) dut (
        .clk     (clk),
        .rst_    (rst_),
`ifdef CTRL_SINGLE_STEP_EN
        .step_en (step_en),
`endif
        .bus     (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase number, wait count, sticky error.
    int m_phase = 0;
    int m_cnt   = 0;
    bit m_err   = 1'b0;

    typedef struct {
        logic [OPW-1:0]  op;
        logic            z;
        logic [7:0][6:0] exp;   // {mem_rd,load_ir,inc_pc,load_ac,load_pc,mem_wr,halt} per phase
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mk(input logic [OPW-1:0] op, input logic z,
                                input logic [6:0] p5, input logic [6:0] p6,
                                input logic [6:0] p7);
        vec_t v;
        v.op     = op;
        v.z      = z;
        v.exp[0] = 7'b0000000;
        v.exp[1] = 7'b1000000;
        v.exp[2] = 7'b1100000;
        v.exp[3] = 7'b1100000;
        v.exp[4] = 7'b0010000;
        v.exp[5] = p5;
        v.exp[6] = p6;
        v.exp[7] = p7;
        return v;
    endfunction

    function automatic int dec(input logic [OPW-1:0] op);
        if (op[OPW-1:3] != 0) return 0;
        return int'(op[2:0]);
    endfunction

    function automatic logic [6:0] exp_strobes(input int ph, input logic [OPW-1:0] op,
                                               input logic z);
        int o;
        bit alu, rd, ir, inc, ac, pc, wr, h;
        o   = dec(op);
        alu = (o >= 2) && (o <= 5);
        {rd, ir, inc, ac, pc, wr, h} = 7'b0;
        case (ph)
            1: rd = 1'b1;
            2, 3: begin rd = 1'b1; ir = 1'b1; end
            4: begin inc = 1'b1; h = (o == 0); end
            5: rd = alu;
            6: begin rd = alu; ac = alu; inc = (o == 1) && z; pc = (o == 7); end
            7: begin rd = alu; ac = alu; pc = (o == 7); inc = (o == 7); wr = (o == 6); end
            8: h = 1'b1;
            default: ;
        endcase
        return {rd, ir, inc, ac, pc, wr, h};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {bus.mem_rd, bus.load_ir, bus.inc_pc, bus.load_ac, bus.load_pc,
                bus.mem_wr, bus.halt, bus.phase, bus.timeout_err};
    endfunction

    function automatic logic [11:0] model_vec();
        return {exp_strobes(m_phase, bus.opcode, bus.zero), 4'(m_phase), m_err};
    endfunction

    task automatic model_clock();
        int o;
        bit alu, wp;
        o   = dec(bus.opcode);
        alu = (o >= 2) && (o <= 5);
        wp  = (m_phase == 1) || ((m_phase == 5) && alu);
        if (m_phase == 8) begin
            if (bus.resume && !m_err) m_phase = 0;
            m_cnt = 0;
        end else if (wp && !bus.mem_ready) begin
            if (m_cnt == WMAX) begin
                m_phase = 8;
                m_err   = 1'b1;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
            if (m_phase == 4 && o == 0) m_phase = 8;
`ifdef CTRL_SINGLE_STEP_EN
            else if (m_phase == 7 && step_en) m_phase = 8;
`endif
            else m_phase = (m_phase + 1) % 8;
        end
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered and left just after a falling edge; inputs are already set.
    task automatic step(input string name);
        #1;
        chk(name, dut_vec(), model_vec());
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic run_to(input int p);
        int n;
        n = 0;
        while (m_phase != p && n < 30) begin
            step("run");
            n++;
        end
        if (m_phase != p) begin
            total++;
            bad++;
            $display("FAIL run_to: model phase %0d, required %0d", m_phase, p);
        end
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        #1;
        chk("reset", dut_vec(), 12'h000);
        m_phase = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        rst_          = 1'b0;
        step_en       = 1'b0;
        bus.opcode    = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        bus.resume    = 1'b0;

        tbl[0] = mk(4'd2, 1'b0, 7'b1000000, 7'b1001000, 7'b1001000); // ADD
        tbl[1] = mk(4'd3, 1'b1, 7'b1000000, 7'b1001000, 7'b1001000); // AND
        tbl[2] = mk(4'd4, 1'b0, 7'b1000000, 7'b1001000, 7'b1001000); // XOR
        tbl[3] = mk(4'd5, 1'b1, 7'b1000000, 7'b1001000, 7'b1001000); // LDA
        tbl[4] = mk(4'd1, 1'b1, 7'b0000000, 7'b0010000, 7'b0000000); // SKZ z=1
        tbl[5] = mk(4'd1, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000); // SKZ z=0
        tbl[6] = mk(4'd6, 1'b0, 7'b0000000, 7'b0000000, 7'b0000010); // STO
        tbl[7] = mk(4'd7, 1'b1, 7'b0000000, 7'b0000100, 7'b0010100); // JMP

        @(negedge clk);
        do_reset();

        // Table-driven: one full instruction per record, mem_ready always high.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
                bus.opcode    = tbl[r].op;
                bus.zero      = tbl[r].z;
                bus.mem_ready = 1'b1;
                #1;
                chk("tbl", dut_vec(), {tbl[r].exp[i], 4'(i), 1'b0});
                step("tbl_model");
            end
        end

        // INST_FETCH held 3 cycles by mem_ready low.
        bus.opcode = 4'd2;
        step("pre_fetch");
        for (int k = 0; k < 4; k++) begin
            bus.mem_ready = (k < 3) ? 1'b0 : 1'b1;
            #1;
            chk("fetch_hold", {bus.mem_rd, bus.phase}, {1'b1, 4'd1});
            step("fetch_hold_m");
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("fetch_adv", {8'b0, bus.phase}, {8'b0, 4'd2});
        run_to(0);

        // mem_ready returning on the last tolerated cycle wins over timeout.
        step("pre_win");
        for (int k = 0; k <= WMAX; k++) begin
            bus.mem_ready = (k < WMAX) ? 1'b0 : 1'b1;
            step("win");
        end
        #1;
        chk("ready_wins", {7'b0, bus.phase, bus.timeout_err}, {7'b0, 4'd2, 1'b0});
        bus.mem_ready = 1'b1;
        run_to(0);

        // OP_FETCH wait, then asynchronous reset mid-wait.
        run_to(5);
        bus.mem_ready = 1'b0;
        step("opf_wait");
        step("opf_wait");
        #2;
        do_reset();
        bus.mem_ready = 1'b1;
        step("after_rst");

        // HLT: halt in OP_ADDR, then HALTED until resume.
        bus.opcode = 4'd0;
        run_to(4);
        #1;
        chk("hlt_opaddr", {bus.halt, bus.inc_pc, bus.phase}, {1'b1, 1'b1, 4'd4});
        step("hlt_go");
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("halted", dut_vec(), {7'b0000001, 4'd8, 1'b0});
            step("halted_m");
        end
        bus.resume = 1'b1;
        step("resume");
        bus.resume = 1'b0;
        #1;
        chk("resumed", {8'b0, bus.phase}, {8'b0, 4'd0});

        // Upper opcode bit decodes as HLT.
        bus.opcode = 4'b1010;
        run_to(4);
        #1;
        chk("hlt_upper", {bus.halt, bus.load_ir, bus.phase}, {1'b1, 1'b0, 4'd4});
        bus.resume = 1'b1;
        step("hu_go");
        step("hu_res");
        bus.resume = 1'b0;
        #1;
        chk("hlt_upper_res", {8'b0, bus.phase}, {8'b0, 4'd0});

`ifdef CTRL_SINGLE_STEP_EN
        step_en    = 1'b1;
        bus.opcode = 4'd2;
        run_to(7);
        step("ss_store");
        #1;
        chk("single_step", {7'b0, bus.halt, bus.phase}, {7'b0, 1'b1, 4'd8});
        step_en    = 1'b0;
        bus.resume = 1'b1;
        step("ss_res");
        bus.resume = 1'b0;
`endif

        // Timeout: WAIT_MAX+1 low cycles in INST_FETCH, resume then ignored.
        bus.opcode = 4'd2;
        run_to(1);
        bus.mem_ready = 1'b0;
        for (int k = 0; k <= WMAX; k++) step("to_wait");
        bus.mem_ready = 1'b1;
        #1;
        chk("timeout", dut_vec(), {7'b0000001, 4'd8, 1'b1});
        bus.resume = 1'b1;
        step("to_resume");
        bus.resume = 1'b0;
        #1;
        chk("timeout_sticky", {7'b0, bus.phase, bus.timeout_err}, {7'b0, 4'd8, 1'b1});
        do_reset();

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if (m_phase == 0) bus.opcode = OPW'($urandom_range(0, 8));
            bus.zero      = 1'($urandom_range(0, 1));
            bus.mem_ready = ($urandom_range(0, 99) < 75);
            bus.resume    = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
